// File: rtl/dense_seq_pkg.sv
// Shared types, default sizing and reference arithmetic for the dense layer sequencer.
package dense_seq_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      MAC  = 1'b1
   } state_t;

   localparam int DEF_N_IN  = 2;
   localparam int DEF_N_OUT = 4;
   localparam int DEF_DW    = 16;
   localparam int DEF_FRAC  = 10;

   // Configuration address map: weights first, then one bias per neuron.
   localparam int N_W       = DEF_N_IN * DEF_N_OUT;
   localparam int BIAS_BASE = N_W;

   // Signed multiply, floor shift by the fractional bits, keep the low word.
   function automatic logic signed [DEF_DW-1:0] mac_term(input logic signed [DEF_DW-1:0] w,
                                                         input logic signed [DEF_DW-1:0] x);
      logic [2*DEF_DW-1:0]        w_ext;
      logic [2*DEF_DW-1:0]        x_ext;
      logic signed [2*DEF_DW-1:0] prod;
      w_ext = {{DEF_DW{w[DEF_DW-1]}}, w};
      x_ext = {{DEF_DW{x[DEF_DW-1]}}, x};
      prod  = w_ext * x_ext;
      return DEF_DW'(prod >>> DEF_FRAC);
   endfunction

   // Negative values clamp to zero, everything else passes through.
   function automatic logic signed [DEF_DW-1:0] relu(input logic signed [DEF_DW-1:0] v);
      return v[DEF_DW-1] ? '0 : v;
   endfunction

endpackage

// File: rtl/dense_layer_seq_if.sv
// Block handshake, input, configuration and result signals of the dense layer sequencer.
interface dense_layer_seq_if #(
   parameter int N_IN = 2,
   parameter int DW   = 16
) ();

   logic                 ap_start;
   logic                 ap_done;
   logic                 ap_idle;
   logic                 ap_ready;
   logic [N_IN*DW-1:0]   input_V;
   logic                 input_V_ap_vld;
   logic                 cfg_we;
   logic [7:0]           cfg_addr;
   logic [DW-1:0]        cfg_data;
   logic                 cfg_err;
   logic [DW-1:0]        out_V;
   logic [7:0]           out_idx;
   logic                 out_V_ap_vld;

   modport master (
      output ap_start, input_V, input_V_ap_vld, cfg_we, cfg_addr, cfg_data,
      input  ap_done, ap_idle, ap_ready, cfg_err, out_V, out_idx, out_V_ap_vld
   );

   modport slave (
      input  ap_start, input_V, input_V_ap_vld, cfg_we, cfg_addr, cfg_data,
      output ap_done, ap_idle, ap_ready, cfg_err, out_V, out_idx, out_V_ap_vld
   );

endinterface

// File: rtl/dense_mac_term.sv
// The one shared multiplier: signed product, floor shift by FRAC, truncated to DW bits.
module dense_mac_term #(
   parameter int DW   = 16,
   parameter int FRAC = 10
) (
   input  logic signed [DW-1:0] w,
   input  logic signed [DW-1:0] x,
   output logic signed [DW-1:0] term
);

   logic [2*DW-1:0]        w_ext;
   logic [2*DW-1:0]        x_ext;
   logic signed [2*DW-1:0] prod;

   // Sign-extend both operands so the low 2*DW bits of the product are the signed result.
   always_comb begin
      w_ext = {{DW{w[DW-1]}}, w};
      x_ext = {{DW{x[DW-1]}}, x};
      prod  = w_ext * x_ext;
      term  = DW'(prod >>> FRAC);
   end

endmodule

// File: rtl/dense_layer_seq.sv
// Time-multiplexed dense layer: one multiplier walks N_OUT neurons over N_IN inputs each.
module dense_layer_seq
   import dense_seq_pkg::*;
#(
   parameter int N_IN  = DEF_N_IN,
   parameter int N_OUT = DEF_N_OUT,
   parameter int DW    = DEF_DW,
   parameter int FRAC  = DEF_FRAC,
   parameter int RELU  = 0
) (
   input  logic            ap_clk,
   input  logic            ap_rst,
   dense_layer_seq_if.slave bus
);

   localparam int KW    = (N_IN  > 1) ? $clog2(N_IN)  : 1;
   localparam int JW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam int NUM_W = N_IN * N_OUT;

   localparam logic [KW-1:0] K_LAST  = KW'(N_IN - 1);
   localparam logic [JW-1:0] J_LAST  = JW'(N_OUT - 1);
   localparam logic [7:0]    BIAS_LO = 8'(NUM_W);

   state_t state_q;
   state_t state_d;

   logic [KW-1:0]        k_q;
   logic [JW-1:0]        j_q;
   logic signed [DW-1:0] acc_q;
   logic signed [DW-1:0] x_q [N_IN];
   logic signed [DW-1:0] w_q [N_OUT][N_IN];
   logic signed [DW-1:0] b_q [N_OUT];

   logic                 accept;
   logic                 last_k;
   logic                 last_j;
   logic signed [DW-1:0] cur_w;
   logic signed [DW-1:0] cur_x;
   logic signed [DW-1:0] term;
   logic signed [DW-1:0] sum;
   logic signed [DW-1:0] bias_first;
   logic signed [DW-1:0] bias_next;

   dense_mac_term #(
      .DW   (DW),
      .FRAC (FRAC)
   ) u_term (
      .w    (cur_w),
      .x    (cur_x),
      .term (term)
   );

   // Next-state logic: start needs valid inputs; the last term of the last neuron returns to IDLE.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      last_k  = 1'b0;
      last_j  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.ap_start && bus.input_V_ap_vld) begin
               accept  = 1'b1;
               state_d = MAC;
            end
         end
         MAC: begin
            last_k = (k_q == K_LAST);
            last_j = (j_q == J_LAST);
            if (last_k && last_j) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand selection; a bias written on the accepting edge must seed the first accumulation.
   always_comb begin
      cur_w      = w_q[j_q][k_q];
      cur_x      = x_q[k_q];
      sum        = acc_q + term;
      bias_next  = b_q[j_q + JW'(1)];
      bias_first = b_q[0];
      if (bus.cfg_we && (bus.cfg_addr == BIAS_LO)) begin
         bias_first = bus.cfg_data;
      end
   end

   // State register.
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Weight and bias storage; writes only land while idle, out-of-map addresses match nothing.
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         for (int jj = 0; jj < N_OUT; jj++) begin
            b_q[jj] <= '0;
            for (int kk = 0; kk < N_IN; kk++) begin
               w_q[jj][kk] <= '0;
            end
         end
      end else if (bus.cfg_we && (state_q == IDLE)) begin
         for (int jj = 0; jj < N_OUT; jj++) begin
            if (bus.cfg_addr == 8'(NUM_W + jj)) begin
               b_q[jj] <= bus.cfg_data;
            end
            for (int kk = 0; kk < N_IN; kk++) begin
               if (bus.cfg_addr == 8'(jj * N_IN + kk)) begin
                  w_q[jj][kk] <= bus.cfg_data;
               end
            end
         end
      end
   end

   // Datapath and registered outputs: accumulate, emit one neuron per N_IN cycles, pulse handshakes.
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         k_q              <= '0;
         j_q              <= '0;
         acc_q            <= '0;
         for (int kk = 0; kk < N_IN; kk++) begin
            x_q[kk] <= '0;
         end
         bus.ap_done      <= 1'b0;
         bus.ap_idle      <= 1'b1;
         bus.ap_ready     <= 1'b0;
         bus.cfg_err      <= 1'b0;
         bus.out_V        <= '0;
         bus.out_idx      <= '0;
         bus.out_V_ap_vld <= 1'b0;
      end else begin
         bus.ap_done      <= 1'b0;
         bus.ap_ready     <= 1'b0;
         bus.out_V_ap_vld <= 1'b0;
         bus.cfg_err      <= bus.cfg_we && (state_q == MAC);
         case (state_q)
            IDLE: begin
               if (accept) begin
                  for (int kk = 0; kk < N_IN; kk++) begin
                     x_q[kk] <= bus.input_V[kk*DW +: DW];
                  end
                  j_q          <= '0;
                  k_q          <= '0;
                  acc_q        <= bias_first;
                  bus.ap_ready <= 1'b1;
                  bus.ap_idle  <= 1'b0;
               end
            end
            MAC: begin
               if (last_k) begin
                  bus.out_V        <= ((RELU != 0) && sum[DW-1]) ? '0 : sum;
                  bus.out_idx      <= 8'(j_q);
                  bus.out_V_ap_vld <= 1'b1;
                  k_q              <= '0;
                  if (last_j) begin
                     bus.ap_done <= 1'b1;
                     bus.ap_idle <= 1'b1;
                  end else begin
                     j_q   <= j_q + JW'(1);
                     acc_q <= bias_next;
                  end
               end else begin
                  acc_q <= sum;
                  k_q   <= k_q + KW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dense_layer_seq.sv
// Self-checking bench for dense_layer_seq: identity and ReLU instances driven in lockstep.
module tb_dense_layer_seq;

   localparam int N_IN  = 2;
   localparam int N_OUT = 4;
   localparam int DW    = 16;
   localparam int NMAC  = N_IN * N_OUT;

   logic ap_clk = 1'b0;
   logic ap_rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   dense_layer_seq_if #(.N_IN(N_IN), .DW(DW)) bus0 ();
   dense_layer_seq_if #(.N_IN(N_IN), .DW(DW)) bus1 ();

   assign bus1.ap_start       = bus0.ap_start;
   assign bus1.input_V        = bus0.input_V;
   assign bus1.input_V_ap_vld = bus0.input_V_ap_vld;
   assign bus1.cfg_we         = bus0.cfg_we;
   assign bus1.cfg_addr       = bus0.cfg_addr;
   assign bus1.cfg_data       = bus0.cfg_data;

   dense_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .FRAC(10), .RELU(0)) dut0 (
      .ap_clk (ap_clk),
      .ap_rst (ap_rst),
      .bus    (bus0)
   );

   dense_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .FRAC(10), .RELU(1)) dut1 (
      .ap_clk (ap_clk),
      .ap_rst (ap_rst),
      .bus    (bus1)
   );

   // Free-running clock.
   always #5 ap_clk = ~ap_clk;

   // Reference configuration as the bench believes it is stored.
   logic signed [15:0] mw [N_OUT][N_IN];
   logic signed [15:0] mb [N_OUT];

   // Observations collected by run_inference.
   logic [15:0] obs_val   [N_OUT];
   logic [15:0] obs_val_r [N_OUT];
   logic [7:0]  obs_idx   [N_OUT];
   int          obs_cyc   [N_OUT];
   int obs_nvld, obs_nready, obs_ready_cyc, obs_ndone, obs_done_cyc, obs_idle_done, obs_err_cyc;

   function automatic longint wrap16(input longint v);
      logic signed [15:0] s;
      s = 16'(v);
      return longint'(s);
   endfunction

   // Neuron j = bias + sum of floor(w*x/1024), all in 16-bit two's complement.
   function automatic logic [15:0] model_neuron(input int j, input logic [15:0] x0,
                                                input logic [15:0] x1, input bit relu_on);
      longint acc, p, t;
      logic signed [15:0] xs [2];
      xs[0] = x0;
      xs[1] = x1;
      acc = longint'(mb[j]);
      for (int k = 0; k < N_IN; k++) begin
         p   = longint'(mw[j][k]) * longint'(xs[k]);
         t   = (p >= 0) ? p / 1024 : -((-p + 1023) / 1024);
         acc = wrap16(acc + wrap16(t));
      end
      if (relu_on && acc < 0) acc = 0;
      return 16'(acc);
   endfunction

   function automatic void model_clear();
      for (int j = 0; j < N_OUT; j++) begin
         mb[j] = '0;
         for (int k = 0; k < N_IN; k++) mw[j][k] = '0;
      end
   endfunction

   // One idle-time configuration write; the model follows the address map.
   task automatic cfg_write(input logic [7:0] a, input logic [15:0] d);
      int ia;
      ia = int'(a);
      bus0.cfg_we   = 1'b1;
      bus0.cfg_addr = a;
      bus0.cfg_data = d;
      @(posedge ap_clk);
      @(negedge ap_clk);
      bus0.cfg_we = 1'b0;
      if (ia < NMAC) mw[ia / N_IN][ia % N_IN] = d;
      else if (ia < NMAC + N_OUT) mb[ia - NMAC] = d;
   endtask

   // Start one inference from idle and record what happens over the next 12 cycles.
   task automatic run_inference(input logic [15:0] x0, input logic [15:0] x1, input int cfg_rel,
                                input logic [7:0] ca, input logic [15:0] cd);
      obs_nvld = 0; obs_nready = 0; obs_ready_cyc = -1; obs_ndone = 0;
      obs_done_cyc = -1; obs_idle_done = -1; obs_err_cyc = -1;
      for (int j = 0; j < N_OUT; j++) begin
         obs_val[j] = 'x; obs_val_r[j] = 'x; obs_idx[j] = 'x; obs_cyc[j] = -1;
      end
      bus0.input_V        = {x1, x0};
      bus0.ap_start       = 1'b1;
      bus0.input_V_ap_vld = 1'b1;
      if (cfg_rel == 0) begin
         bus0.cfg_we = 1'b1; bus0.cfg_addr = ca; bus0.cfg_data = cd;
      end
      @(posedge ap_clk);
      for (int rel = 1; rel <= 12; rel++) begin
         @(negedge ap_clk);
         if (rel == 1) begin
            bus0.ap_start       = 1'b0;
            bus0.input_V_ap_vld = 1'b0;
            bus0.input_V        = $urandom;
         end
         bus0.cfg_we = 1'b0;
         if (rel == cfg_rel) begin
            bus0.cfg_we = 1'b1; bus0.cfg_addr = ca; bus0.cfg_data = cd;
         end
         if (bus0.ap_ready) begin obs_nready++; obs_ready_cyc = rel; end
         if (bus0.out_V_ap_vld) begin
            if (obs_nvld < N_OUT) begin
               obs_val[obs_nvld]   = bus0.out_V;
               obs_val_r[obs_nvld] = bus1.out_V;
               obs_idx[obs_nvld]   = bus0.out_idx;
               obs_cyc[obs_nvld]   = rel;
            end
            obs_nvld++;
         end
         if (bus0.ap_done) begin obs_ndone++; obs_done_cyc = rel; obs_idle_done = int'(bus0.ap_idle); end
         if (bus0.cfg_err && obs_err_cyc < 0) obs_err_cyc = rel;
      end
      bus0.cfg_we = 1'b0;
   endtask

   task automatic test_reset();
      #1 ap_rst = 1'b1;
      @(negedge ap_clk);
      checks++; if (bus0.ap_idle !== 1'b1) begin errors++; $display("[TB] FAIL reset_idle got %b want 1", bus0.ap_idle); end
      checks++; if (bus0.ap_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %b want 0", bus0.ap_ready); end
      checks++; if (bus0.ap_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", bus0.ap_done); end
      checks++; if (bus0.out_V_ap_vld !== 1'b0) begin errors++; $display("[TB] FAIL reset_vld got %b want 0", bus0.out_V_ap_vld); end
      checks++; if (bus0.cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", bus0.cfg_err); end
      checks++; if (bus0.out_V !== 16'h0) begin errors++; $display("[TB] FAIL reset_outv got %h want 0000", bus0.out_V); end
      checks++; if (bus0.out_idx !== 8'h0) begin errors++; $display("[TB] FAIL reset_idx got %h want 00", bus0.out_idx); end
      checks++; if (bus1.ap_idle !== 1'b1) begin errors++; $display("[TB] FAIL reset_idle_relu got %b want 1", bus1.ap_idle); end
      ap_rst = 1'b0;
      model_clear();
      @(negedge ap_clk);
   endtask

   task automatic test_known_vectors();
      cfg_write(8'd0, 16'hFEE0);
      cfg_write(8'd1, 16'd304);
      cfg_write(8'd8, 16'd157);
      run_inference(16'd1024, 16'd1024, -1, 8'd0, 16'd0);
      checks++; if (obs_val[0] !== 16'd173) begin errors++; $display("[TB] FAIL known_n0 got %h want %h", obs_val[0], 16'd173); end
      checks++; if (obs_idx[0] !== 8'd0) begin errors++; $display("[TB] FAIL known_idx0 got %0d want 0", obs_idx[0]); end
      checks++; if (obs_ready_cyc !== 1) begin errors++; $display("[TB] FAIL known_ready_cycle got %0d want 1", obs_ready_cyc); end
      checks++; if (obs_nready !== 1) begin errors++; $display("[TB] FAIL known_ready_count got %0d want 1", obs_nready); end
      checks++; if (obs_nvld !== N_OUT) begin errors++; $display("[TB] FAIL known_vld_count got %0d want %0d", obs_nvld, N_OUT); end
      checks++; if (obs_done_cyc !== NMAC + 1) begin errors++; $display("[TB] FAIL known_done_cycle got %0d want %0d", obs_done_cyc, NMAC + 1); end
      checks++; if (obs_ndone !== 1) begin errors++; $display("[TB] FAIL known_done_count got %0d want 1", obs_ndone); end
      checks++; if (obs_idle_done !== 1) begin errors++; $display("[TB] FAIL known_idle_at_done got %0d want 1", obs_idle_done); end
      for (int j = 0; j < N_OUT; j++) begin
         checks++; if (obs_cyc[j] !== 1 + (j + 1) * N_IN) begin errors++; $display("[TB] FAIL known_vld_cycle%0d got %0d want %0d", j, obs_cyc[j], 1 + (j + 1) * N_IN); end
         checks++; if (obs_val[j] !== model_neuron(j, 16'd1024, 16'd1024, 1'b0)) begin errors++; $display("[TB] FAIL known_val%0d got %h want %h", j, obs_val[j], model_neuron(j, 16'd1024, 16'd1024, 1'b0)); end
      end
      run_inference(16'd2048, 16'd0, -1, 8'd0, 16'd0);
      checks++; if (obs_val[0] !== 16'hFE5D) begin errors++; $display("[TB] FAIL known_neg got %h want FE5D", obs_val[0]); end
      checks++; if (obs_val_r[0] !== 16'h0000) begin errors++; $display("[TB] FAIL known_neg_relu got %h want 0000", obs_val_r[0]); end
   endtask

   task automatic test_floor_wrap();
      cfg_write(8'd0, 16'd1);
      cfg_write(8'd1, 16'd0);
      cfg_write(8'd8, 16'd0);
      run_inference(16'd1, 16'd0, -1, 8'd0, 16'd0);
      checks++; if (obs_val[0] !== 16'h0000) begin errors++; $display("[TB] FAIL floor_pos got %h want 0000", obs_val[0]); end
      cfg_write(8'd0, 16'hFFFF);
      run_inference(16'd1, 16'd0, -1, 8'd0, 16'd0);
      checks++; if (obs_val[0] !== 16'hFFFF) begin errors++; $display("[TB] FAIL floor_neg got %h want FFFF", obs_val[0]); end
      checks++; if (obs_val_r[0] !== 16'h0000) begin errors++; $display("[TB] FAIL floor_neg_relu got %h want 0000", obs_val_r[0]); end
      cfg_write(8'd0, 16'd32767);
      run_inference(16'd32767, 16'd0, -1, 8'd0, 16'd0);
      checks++; if (obs_val[0] !== 16'hFFC0) begin errors++; $display("[TB] FAIL wrap_max got %h want FFC0", obs_val[0]); end
      checks++; if (obs_val_r[0] !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_max_relu got %h want 0000", obs_val_r[0]); end
   endtask

   task automatic test_random();
      logic [15:0] x0, x1;
      for (int a = 0; a < NMAC + N_OUT; a++) cfg_write(8'(a), 16'($urandom));
      for (int r = 0; r < 4; r++) begin
         x0 = 16'($urandom);
         x1 = 16'($urandom);
         run_inference(x0, x1, -1, 8'd0, 16'd0);
         checks++; if (obs_nvld !== N_OUT) begin errors++; $display("[TB] FAIL rand_vld_count got %0d want %0d", obs_nvld, N_OUT); end
         for (int j = 0; j < N_OUT; j++) begin
            checks++; if (obs_val[j] !== model_neuron(j, x0, x1, 1'b0)) begin errors++; $display("[TB] FAIL rand_val%0d got %h want %h", j, obs_val[j], model_neuron(j, x0, x1, 1'b0)); end
            checks++; if (obs_val_r[j] !== model_neuron(j, x0, x1, 1'b1)) begin errors++; $display("[TB] FAIL rand_relu%0d got %h want %h", j, obs_val_r[j], model_neuron(j, x0, x1, 1'b1)); end
            checks++; if (obs_idx[j] !== 8'(j)) begin errors++; $display("[TB] FAIL rand_idx%0d got %0d want %0d", j, obs_idx[j], j); end
         end
      end
   endtask

   // Start held high: vld toggles for the first half, then stays high for back-to-back runs.
   task automatic test_back_to_back();
      localparam int NB = 80;
      bit          e_vld [NB + 16];
      bit          e_rdy [NB + 16];
      bit          e_done [NB + 16];
      bit          e_busy [NB + 16];
      logic [15:0] e_val [NB + 16];
      logic [15:0] e_valr [NB + 16];
      logic [7:0]  e_idx [NB + 16];
      logic [31:0] xv;
      int          free_edge;
      int          c;
      for (int i = 0; i < NB + 16; i++) begin
         e_vld[i] = 0; e_rdy[i] = 0; e_done[i] = 0; e_busy[i] = 0;
         e_val[i] = '0; e_valr[i] = '0; e_idx[i] = '0;
      end
      free_edge = 0;
      for (int n = 0; n < NB; n++) begin
         xv = $urandom;
         bus0.input_V        = xv;
         bus0.input_V_ap_vld = (n < 40) ? (n % 2 == 1) : 1'b1;
         bus0.ap_start       = (n < NB - 12);
         @(posedge ap_clk);
         if (bus0.ap_start && bus0.input_V_ap_vld && n >= free_edge) begin
            free_edge = n + NMAC + 1;
            e_rdy[n + 1] = 1;
            e_done[n + NMAC + 1] = 1;
            for (int q = n + 1; q <= n + NMAC; q++) e_busy[q] = 1;
            for (int j = 0; j < N_OUT; j++) begin
               c = n + 1 + (j + 1) * N_IN;
               e_vld[c]  = 1;
               e_val[c]  = model_neuron(j, xv[15:0], xv[31:16], 1'b0);
               e_valr[c] = model_neuron(j, xv[15:0], xv[31:16], 1'b1);
               e_idx[c]  = 8'(j);
            end
         end
         @(negedge ap_clk);
         c = n + 1;
         checks++; if (bus0.out_V_ap_vld !== e_vld[c]) begin errors++; $display("[TB] FAIL b2b_vld cycle %0d got %b want %b", c, bus0.out_V_ap_vld, e_vld[c]); end
         checks++; if (bus0.ap_ready !== e_rdy[c]) begin errors++; $display("[TB] FAIL b2b_ready cycle %0d got %b want %b", c, bus0.ap_ready, e_rdy[c]); end
         checks++; if (bus0.ap_done !== e_done[c]) begin errors++; $display("[TB] FAIL b2b_done cycle %0d got %b want %b", c, bus0.ap_done, e_done[c]); end
         checks++; if (bus0.ap_idle !== !e_busy[c]) begin errors++; $display("[TB] FAIL b2b_idle cycle %0d got %b want %b", c, bus0.ap_idle, !e_busy[c]); end
         if (e_vld[c]) begin
            checks++; if (bus0.out_V !== e_val[c]) begin errors++; $display("[TB] FAIL b2b_val cycle %0d got %h want %h", c, bus0.out_V, e_val[c]); end
            checks++; if (bus1.out_V !== e_valr[c]) begin errors++; $display("[TB] FAIL b2b_relu cycle %0d got %h want %h", c, bus1.out_V, e_valr[c]); end
            checks++; if (bus0.out_idx !== e_idx[c]) begin errors++; $display("[TB] FAIL b2b_idx cycle %0d got %0d want %0d", c, bus0.out_idx, e_idx[c]); end
         end
      end
      bus0.ap_start       = 1'b0;
      bus0.input_V_ap_vld = 1'b0;
   endtask

   task automatic test_cfg_busy();
      logic [15:0] x0, x1, nb, want0;
      x0 = 16'($urandom);
      x1 = 16'($urandom);
      nb = mb[0] + 16'd77;
      run_inference(x0, x1, 4, 8'(NMAC), nb);
      checks++; if (obs_err_cyc !== 5) begin errors++; $display("[TB] FAIL busy_err_cycle got %0d want 5", obs_err_cyc); end
      checks++; if (obs_val[0] !== model_neuron(0, x0, x1, 1'b0)) begin errors++; $display("[TB] FAIL busy_val got %h want %h", obs_val[0], model_neuron(0, x0, x1, 1'b0)); end
      want0 = model_neuron(0, x0, x1, 1'b0);
      run_inference(x0, x1, NMAC + 1, 8'(NMAC), nb);
      checks++; if (obs_err_cyc !== -1) begin errors++; $display("[TB] FAIL idle_err_cycle got %0d want -1", obs_err_cyc); end
      checks++; if (obs_val[0] !== want0) begin errors++; $display("[TB] FAIL idle_write_late got %h want %h", obs_val[0], want0); end
      mb[0] = nb;
      run_inference(x0, x1, -1, 8'd0, 16'd0);
      checks++; if (obs_val[0] !== model_neuron(0, x0, x1, 1'b0)) begin errors++; $display("[TB] FAIL idle_write_used got %h want %h", obs_val[0], model_neuron(0, x0, x1, 1'b0)); end
   endtask

   task automatic test_cfg_on_start();
      logic [15:0] x0, x1, nv;
      x0 = 16'($urandom);
      x1 = 16'($urandom);
      nv = 16'($urandom);
      mb[0] = nv;
      run_inference(x0, x1, 0, 8'(NMAC), nv);
      checks++; if (obs_val[0] !== model_neuron(0, x0, x1, 1'b0)) begin errors++; $display("[TB] FAIL start_bias got %h want %h", obs_val[0], model_neuron(0, x0, x1, 1'b0)); end
      checks++; if (obs_err_cyc !== -1) begin errors++; $display("[TB] FAIL start_err got %0d want -1", obs_err_cyc); end
      nv = 16'($urandom);
      mw[0][1] = nv;
      run_inference(x0, x1, 0, 8'd1, nv);
      checks++; if (obs_val[0] !== model_neuron(0, x0, x1, 1'b0)) begin errors++; $display("[TB] FAIL start_weight got %h want %h", obs_val[0], model_neuron(0, x0, x1, 1'b0)); end
   endtask

   task automatic test_out_of_range();
      logic [15:0] x0, x1;
      cfg_write(8'(NMAC + N_OUT), 16'($urandom));
      checks++; if (bus0.cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL oor_err got %b want 0", bus0.cfg_err); end
      cfg_write(8'd255, 16'($urandom));
      x0 = 16'($urandom);
      x1 = 16'($urandom);
      run_inference(x0, x1, -1, 8'd0, 16'd0);
      for (int j = 0; j < N_OUT; j++) begin
         checks++; if (obs_val[j] !== model_neuron(j, x0, x1, 1'b0)) begin errors++; $display("[TB] FAIL oor_val%0d got %h want %h", j, obs_val[j], model_neuron(j, x0, x1, 1'b0)); end
      end
   endtask

   task automatic test_reset_mid();
      int stray;
      logic [15:0] x0, x1;
      bus0.input_V        = $urandom;
      bus0.ap_start       = 1'b1;
      bus0.input_V_ap_vld = 1'b1;
      @(posedge ap_clk);
      @(negedge ap_clk);
      bus0.ap_start       = 1'b0;
      bus0.input_V_ap_vld = 1'b0;
      repeat (3) @(negedge ap_clk);
      #2 ap_rst = 1'b1;
      #1;
      checks++; if (bus0.ap_idle !== 1'b1) begin errors++; $display("[TB] FAIL mid_rst_idle got %b want 1", bus0.ap_idle); end
      checks++; if (bus0.out_V !== 16'h0) begin errors++; $display("[TB] FAIL mid_rst_outv got %h want 0000", bus0.out_V); end
      checks++; if (bus0.out_V_ap_vld !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_vld got %b want 0", bus0.out_V_ap_vld); end
      @(negedge ap_clk);
      ap_rst = 1'b0;
      model_clear();
      stray = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge ap_clk);
         if (bus0.out_V_ap_vld || bus0.ap_done) stray++;
      end
      checks++; if (stray !== 0) begin errors++; $display("[TB] FAIL mid_rst_stray got %0d want 0", stray); end
      x0 = 16'($urandom);
      x1 = 16'($urandom);
      run_inference(x0, x1, -1, 8'd0, 16'd0);
      for (int j = 0; j < N_OUT; j++) begin
         checks++; if (obs_val[j] !== model_neuron(j, x0, x1, 1'b0)) begin errors++; $display("[TB] FAIL mid_rst_val%0d got %h want %h", j, obs_val[j], model_neuron(j, x0, x1, 1'b0)); end
      end
   endtask

   // Test sequence.
   initial begin
      bus0.ap_start       = 1'b0;
      bus0.input_V        = '0;
      bus0.input_V_ap_vld = 1'b0;
      bus0.cfg_we         = 1'b0;
      bus0.cfg_addr       = '0;
      bus0.cfg_data       = '0;
      test_reset();
      test_known_vectors();
      test_floor_wrap();
      test_random();
      test_back_to_back();
      test_cfg_busy();
      test_cfg_on_start();
      test_out_of_range();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Bound on total run time.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog got timeout want finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/dense_layer_seq.md
Name: dense_layer_seq

Overview:
- Sequencer for a time-multiplexed dense layer: one shared signed 16x16 multiplier computes N_OUT neurons over N_IN inputs.
- Fixed-point scaling matches the existing layer datapath: product bits [FRAC+15:FRAC] and a per-neuron bias.
- Sits between the input register stage and the next layer.
- Uses the ap_start/ap_done/ap_idle/ap_ready block handshake and a runtime weight/bias configuration port.

Parameters:
N_IN, 2, inputs per neuron (>=1)
N_OUT, 4, neurons (>=1)
DW, 16, data/weight/bias width, signed
FRAC, 10, product right-shift (fractional bits)
RELU, 0, 1 = clamp negative results to 0 at output

Ports:
ap_clk  in  1  clock
ap_rst  in  1  asynchronous active-high reset
ap_start  in  1  request one inference
ap_done  out  1  one-cycle pulse, last neuron emitted
ap_idle  out  1  high while in IDLE
ap_ready  out  1  one-cycle pulse, inputs captured
input_V  in  N_IN*DW  packed inputs, x[k] = input_V[k*DW+:DW]
input_V_ap_vld  in  1  input_V valid
cfg_we  in  1  config write strobe
cfg_addr  in  8  weight w[j][k] at j*N_IN+k; bias b[j] at N_IN*N_OUT+j
cfg_data  in  DW  config value, signed
cfg_err  out  1  one-cycle pulse, write dropped because busy
out_V  out  DW  neuron result
out_idx  out  8  neuron index j of out_V
out_V_ap_vld  out  1  one-cycle pulse per neuron

Behaviour:
- Clock and reset: one clock, ap_clk. Reset ap_rst is asynchronous, active-high.
- Reset values: ap_idle=1; ap_done, ap_ready, out_V_ap_vld and cfg_err=0; out_V=0; out_idx=0. All weights, biases and the x latch clear to 0; state=IDLE.
- Reset mid-inference aborts immediately. No out_V_ap_vld or ap_done follows.
- All outputs are registered.
- FSM states IDLE, MAC:
  - IDLE: on an edge with ap_start=1 and input_V_ap_vld=1, latch x, set j=0, k=0, acc=b[0], go to MAC. ap_ready=1 and ap_idle=0 for the next cycle.
  - IDLE with ap_start=1 but input_V_ap_vld=0: wait. No ready pulse.
  - MAC: each cycle acc <= acc + term(w[j][k], x[k]) and k increments.
  - At k=N_IN-1: out_V <= act(acc + term); out_idx <= j; out_V_ap_vld pulses. Then k=0 and acc=b[j+1], or go to IDLE if j=N_OUT-1.
- term = (signed w * signed x) with full 2*DW product, arithmetic shift right by FRAC (floor), truncated to the low DW bits.
- acc is DW bits and wraps modulo 2^DW (two's complement). No saturation.
- act = identity if RELU=0. If RELU=1, any negative value (MSB=1) becomes 0.
- Timing, with start sampled at edge S:
  - MAC occupies cycles S+1 .. S+N_OUT*N_IN.
  - out_V_ap_vld for neuron j is high in cycle S+1+(j+1)*N_IN, overlapping the next neuron's first MAC cycle.
  - ap_done=1 and ap_idle=1 together in cycle S+1+N_OUT*N_IN.
  - A start sampled at that cycle's ending edge is accepted (back-to-back), giving throughput of one inference per N_OUT*N_IN+1 cycles.
- input_V changes after ap_ready do not affect the running inference.
- Config writes:
  - Applied at the edge when cfg_we=1 and state=IDLE, including the edge that accepts ap_start. The new value is used by that inference.
  - Write while in MAC: dropped, cfg_err pulses for one cycle.
  - cfg_addr >= N_IN*N_OUT+N_OUT: ignored silently.

Decomposition:
- Package dense_seq_pkg:
  - state enum {IDLE, MAC}
  - localparams N_W=N_IN*N_OUT, BIAS_BASE=N_W
  - function mac_term(w, x) implementing the multiply/shift/truncate rule
  - function relu(v)
- One sub-module, dense_mac_term: combinational multiply/shift/truncate. It isolates the single multiplier so synthesis maps it to one DSP.

Test Plan:
- Config w[0][0]=-288 (0xFEE0), w[0][1]=304, b[0]=157; x=(1024,1024); RELU=0 -> neuron 0 out_V=173, out_idx=0. Pulse at S+3, ap_ready at S+1, ap_done at S+9.
- Same weights, x=(2048,0) -> RELU=0: out_V=0xFE5D (-419). RELU=1: out_V=0.
- Floor and wrap: w=1,x=1 -> term 0; w=-1,x=1 -> term -1. w=32767,x=32767, b=0, other weight 0 -> out_V=0xFFC0 (-64).
- ap_start held high with input_V_ap_vld toggling each cycle:
  - Start is accepted only when vld=1.
  - Back-to-back inferences occur every 9 cycles with N_IN=2, N_OUT=4.
  - Each run's results match its own latched x.
- cfg_we during MAC -> cfg_err pulse, results unchanged. cfg_we on the start edge -> new value used. Out-of-range cfg_addr -> no effect.
- ap_rst asserted mid-MAC (between clock edges) -> outputs reset immediately with ap_idle=1. No further out_V_ap_vld, and weights read back as 0 on the next run.
